// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and request bundle.
// Used by the ALU and by the arbiter front end.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef struct packed {
    logic [3:0]  opc;
    logic        sel_pc;
    logic [31:0] pc;
    logic [31:0] reg1;
    logic [31:0] src2;
  } alu_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, ALU-drive and response signals of alu_arbiter.
// slave = arbiter side, master = requester/consumer side.
interface alu_arbiter_if;

  logic        r0_valid;
  logic        r0_ready;
  logic [3:0]  r0_opc;
  logic        r0_sel_pc;
  logic [31:0] r0_pc;
  logic [31:0] r0_reg1;
  logic [31:0] r0_src2;

  logic        r1_valid;
  logic        r1_ready;
  logic [3:0]  r1_opc;
  logic        r1_sel_pc;
  logic [31:0] r1_pc;
  logic [31:0] r1_reg1;
  logic [31:0] r1_src2;

  logic [3:0]  exe_alu_opc_r;
  logic        exe_sel_pc_r;
  logic [31:0] exe_pc_r;
  logic [31:0] exe_reg1_r;
  logic [31:0] exe_src2_r;
  logic [31:0] alu_result;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;

  modport slave (
    input  r0_valid, r0_opc, r0_sel_pc,
    input  r0_pc, r0_reg1, r0_src2,
    output r0_ready,
    input  r1_valid, r1_opc, r1_sel_pc,
    input  r1_pc, r1_reg1, r1_src2,
    output r1_ready,
    output exe_alu_opc_r, exe_sel_pc_r,
    output exe_pc_r, exe_reg1_r, exe_src2_r,
    input  alu_result,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready
  );

  modport master (
    output r0_valid, r0_opc, r0_sel_pc,
    output r0_pc, r0_reg1, r0_src2,
    input  r0_ready,
    output r1_valid, r1_opc, r1_sel_pc,
    output r1_pc, r1_reg1, r1_src2,
    input  r1_ready,
    input  exe_alu_opc_r, exe_sel_pc_r,
    input  exe_pc_r, exe_reg1_r, exe_src2_r,
    output alu_result,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready
  );

endinterface

// File: rtl/alu.sv
// Combinational RV32I ALU.
// First operand is PC or reg1, second is src2.
module alu
  import alu_pkg::*;
(
  input  logic [3:0]  i_opc,
  input  logic        i_sel_pc,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_reg1,
  input  logic [31:0] i_src2,
  output logic [31:0] o_result
);

  logic [31:0] w_a;
  logic [4:0]  w_sh;

  assign w_a  = i_sel_pc ? i_pc : i_reg1;
  assign w_sh = i_src2[4:0];

  // opcode decode to result
  always_comb begin
    o_result = '0;
    unique case (i_opc)
      ALU_ADD:  o_result = w_a + i_src2;
      ALU_SUB:  o_result = w_a - i_src2;
      ALU_SLL:  o_result = w_a << w_sh;
      ALU_SLT:  o_result = {31'b0, $signed(w_a) < $signed(i_src2)};
      ALU_SLTU: o_result = {31'b0, w_a < i_src2};
      ALU_XOR:  o_result = w_a ^ i_src2;
      ALU_SRL:  o_result = w_a >> w_sh;
      ALU_SRA:  o_result = $unsigned($signed(w_a) >>> w_sh);
      ALU_OR:   o_result = w_a | i_src2;
      ALU_AND:  o_result = w_a & i_src2;
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way arbiter, round-robin or fixed priority (0 wins).
// Pointer remembers the last accepted requester.
module rr_arbiter2 #(
  parameter int RR_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_valid,
  input  logic       i_free,
  output logic [1:0] o_ready
);

  logic       r_last;
  logic [1:0] w_grant;

  // pick a winner among the valid requesters
  always_comb begin
    w_grant = 2'b00;
    unique case (1'b1)
      (i_valid[0] & i_valid[1]):
        w_grant = (RR_EN != 0 && !r_last) ? 2'b10 : 2'b01;
      (i_valid[0] & !i_valid[1]):
        w_grant = 2'b01;
      (!i_valid[0] & i_valid[1]):
        w_grant = 2'b10;
      default:
        w_grant = 2'b00;
    endcase
  end

  assign o_ready = w_grant & i_valid & {2{i_free}};

  // pointer moves only on an accepted transfer; reset favours 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (|o_ready) begin
      r_last <= o_ready[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: arbitrate, issue, register result.
// Issue stage drives the external ALU; response stage holds its output.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  logic        w_adv;
  logic        w_free;
  logic        w_acc;
  logic [1:0]  w_valid;
  logic [1:0]  w_ready;
  alu_req_t    w_req0;
  alu_req_t    w_req1;
  alu_req_t    w_win;

  logic        r_issue_v;
  logic        r_issue_id;
  alu_req_t    r_exe;
  logic        r_rsp_v;
  logic        r_rsp_id;
  logic [31:0] r_rsp_data;

  assign w_adv   = !r_rsp_v | bus.rsp_ready;
  assign w_free  = !r_issue_v | w_adv;
  assign w_valid = {bus.r1_valid, bus.r0_valid};
  assign w_acc   = |w_ready;

  assign w_req0 = '{opc: bus.r0_opc, sel_pc: bus.r0_sel_pc,
                    pc: bus.r0_pc, reg1: bus.r0_reg1,
                    src2: bus.r0_src2};
  assign w_req1 = '{opc: bus.r1_opc, sel_pc: bus.r1_sel_pc,
                    pc: bus.r1_pc, reg1: bus.r1_reg1,
                    src2: bus.r1_src2};
  assign w_win  = w_ready[1] ? w_req1 : w_req0;

  rr_arbiter2 #(
    .RR_EN (RR_EN)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_valid),
    .i_free  (w_free),
    .o_ready (w_ready)
  );

  // issue stage: load the winner, drain when it moves on
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_issue_v  <= 1'b0;
      r_issue_id <= 1'b0;
      r_exe      <= '{opc: ALU_ADD, sel_pc: 1'b0,
                      pc: '0, reg1: '0, src2: '0};
    end else if (w_acc) begin
      r_issue_v  <= 1'b1;
      r_issue_id <= w_ready[1];
      r_exe      <= w_win;
    end else if (w_adv) begin
      r_issue_v  <= 1'b0;
    end
  end

  // response stage: capture ALU output, clear when consumed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_v    <= 1'b0;
      r_rsp_id   <= 1'b0;
      r_rsp_data <= '0;
    end else if (r_issue_v & w_adv) begin
      r_rsp_v    <= 1'b1;
      r_rsp_id   <= r_issue_id;
      r_rsp_data <= bus.alu_result;
    end else if (bus.rsp_ready) begin
      r_rsp_v    <= 1'b0;
    end
  end

  assign bus.r0_ready      = w_ready[0];
  assign bus.r1_ready      = w_ready[1];
  assign bus.exe_alu_opc_r = r_exe.opc;
  assign bus.exe_sel_pc_r  = r_exe.sel_pc;
  assign bus.exe_pc_r      = r_exe.pc;
  assign bus.exe_reg1_r    = r_exe.reg1;
  assign bus.exe_src2_r    = r_exe.src2;
  assign bus.rsp_valid     = r_rsp_v;
  assign bus.rsp_id        = r_rsp_id;
  assign bus.rsp_data      = r_rsp_data;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with an external ALU.
// Scoreboard model tracks in-flight ops, grants and results.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if bus1 ();
  alu_arbiter_if bus0 ();

  alu_arbiter #(.RR_EN(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));
  alu_arbiter #(.RR_EN(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));

  alu u_alu1 (
    .i_opc(bus1.exe_alu_opc_r), .i_sel_pc(bus1.exe_sel_pc_r),
    .i_pc(bus1.exe_pc_r), .i_reg1(bus1.exe_reg1_r),
    .i_src2(bus1.exe_src2_r), .o_result(bus1.alu_result));
  alu u_alu0 (
    .i_opc(bus0.exe_alu_opc_r), .i_sel_pc(bus0.exe_sel_pc_r),
    .i_pc(bus0.exe_pc_r), .i_reg1(bus0.exe_reg1_r),
    .i_src2(bus0.exe_src2_r), .o_result(bus0.alu_result));

  typedef struct {
    bit          id;
    logic [31:0] data;
    int          e;
  } exp_t;

  typedef struct {
    bit          who;
    logic [3:0]  opc;
    bit          sp;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] s2;
    logic [31:0] res;
  } vec_t;

  exp_t        q[$];
  vec_t        tv[12];
  logic [3:0]  ops[10];
  logic [3:0]  ops4[4];
  int          ecnt = 0;
  int          last = 1;
  int          checks = 0;
  int          errors = 0;
  bit          acc0, acc1;

  function automatic logic [31:0] ref_alu(
    input logic [3:0] opc, input logic [31:0] a,
    input logic [31:0] b);
    logic [31:0] m;
    int s;
    s = int'(b % 32);
    m = 32'hffffffff;
    case (opc)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a + (~b) + 32'd1;
      ALU_SLL:  return a << s;
      ALU_SRL:  return a >> s;
      ALU_SRA:  return (a >> s) | (a[31] ? ~(m >> s) : 32'd0);
      ALU_SLT:  return ((a ^ 32'h80000000) < (b ^ 32'h80000000))
                       ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  // Model check and update, run just before each rising edge.
  task automatic monitor();
    bit ev, v0, v1, free, e0, e1;
    int w;
    exp_t it;
    ev = (q.size() >= 2) || (q.size() == 1 && q[0].e < ecnt);
    chk1("rsp_valid", bus1.rsp_valid, ev);
    if (ev) begin
      chk1("rsp_id", bus1.rsp_id, q[0].id);
      chk("rsp_data", bus1.rsp_data, q[0].data);
    end
    free = (q.size() < 2) || bus1.rsp_ready;
    v0 = bus1.r0_valid;
    v1 = bus1.r1_valid;
    if (v0 && v1) w = (last == 1) ? 0 : 1;
    else w = v0 ? 0 : 1;
    e0 = v0 && free && (w == 0);
    e1 = v1 && free && (w == 1);
    chk1("r0_ready", bus1.r0_ready, e0);
    chk1("r1_ready", bus1.r1_ready, e1);
    acc0 = e0;
    acc1 = e1;
    if (ev && bus1.rsp_ready) void'(q.pop_front());
    if (e0) begin
      it.id = 1'b0;
      it.data = ref_alu(bus1.r0_opc,
        bus1.r0_sel_pc ? bus1.r0_pc : bus1.r0_reg1, bus1.r0_src2);
      it.e = ecnt + 1;
      q.push_back(it);
      last = 0;
    end
    if (e1) begin
      it.id = 1'b1;
      it.data = ref_alu(bus1.r1_opc,
        bus1.r1_sel_pc ? bus1.r1_pc : bus1.r1_reg1, bus1.r1_src2);
      it.e = ecnt + 1;
      q.push_back(it);
      last = 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic set_req(input bit n, input bit v,
    input logic [3:0] opc, input bit sp, input logic [31:0] pc,
    input logic [31:0] r1, input logic [31:0] s2);
    if (!n) begin
      bus1.r0_valid = v; bus1.r0_opc = opc;
      bus1.r0_sel_pc = sp; bus1.r0_pc = pc;
      bus1.r0_reg1 = r1; bus1.r0_src2 = s2;
    end else begin
      bus1.r1_valid = v; bus1.r1_opc = opc;
      bus1.r1_sel_pc = sp; bus1.r1_pc = pc;
      bus1.r1_reg1 = r1; bus1.r1_src2 = s2;
    end
  endtask

  task automatic rand_req(input bit n, input int pct);
    set_req(n, $urandom_range(0, 99) < pct,
      ops[$urandom_range(0, 9)], 1'($urandom_range(0, 1)),
      $urandom, $urandom, $urandom);
  endtask

  // Requesters may only change operands when idle or just accepted.
  task automatic refresh(input int pct);
    if (!bus1.r0_valid || acc0) rand_req(1'b0, pct);
    if (!bus1.r1_valid || acc1) rand_req(1'b1, pct);
  endtask

  initial begin
    logic [31:0] d, s;
    logic [3:0]  o;
    logic        id;
    int cnt, run, maxrun;

    ops = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
            ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND};
    ops4 = '{ALU_XOR, ALU_SUB, ALU_SLT, ALU_SRA};

    tv[0]  = '{0, ALU_ADD,  0, 32'h0, 32'd5, 32'd7, 32'd12};
    tv[1]  = '{1, ALU_ADD,  1, 32'h100, 32'hdead, 32'd4, 32'h104};
    tv[2]  = '{0, ALU_SUB,  0, 32'h0, 32'd3, 32'd5, 32'hfffffffe};
    tv[3]  = '{1, ALU_SLT,  0, 32'h0, 32'hffffffff, 32'd1, 32'd1};
    tv[4]  = '{0, ALU_SLTU, 0, 32'h0, 32'hffffffff, 32'd1, 32'd0};
    tv[5]  = '{1, ALU_SRA,  0, 32'h0, 32'h80000000, 32'd4,
               32'hf8000000};
    tv[6]  = '{0, ALU_SRL,  0, 32'h0, 32'h80000000, 32'd4,
               32'h08000000};
    tv[7]  = '{1, ALU_SLL,  0, 32'h0, 32'd1, 32'd31, 32'h80000000};
    tv[8]  = '{0, ALU_AND,  0, 32'h0, 32'hf0f0, 32'hff00, 32'hf000};
    tv[9]  = '{1, ALU_OR,   0, 32'h0, 32'hf0f0, 32'h0f00, 32'hfff0};
    tv[10] = '{0, ALU_XOR,  1, 32'haaaa, 32'h0, 32'hffff, 32'h5555};
    tv[11] = '{1, ALU_SLT,  0, 32'h0, 32'd5, 32'hfffffffb, 32'd0};

    set_req(1'b0, 1'b0, ALU_ADD, 1'b0, 0, 0, 0);
    set_req(1'b1, 1'b0, ALU_ADD, 1'b0, 0, 0, 0);
    bus1.rsp_ready = 1'b1;
    bus0.r0_valid = 0; bus0.r0_opc = ALU_ADD; bus0.r0_sel_pc = 0;
    bus0.r0_pc = 0; bus0.r0_reg1 = 32'd1; bus0.r0_src2 = 32'd1;
    bus0.r1_valid = 0; bus0.r1_opc = ALU_ADD; bus0.r1_sel_pc = 0;
    bus0.r1_pc = 0; bus0.r1_reg1 = 32'd2; bus0.r1_src2 = 32'd2;
    bus0.rsp_ready = 1'b1;

    #12;
    chk1("rst_rsp_valid", bus1.rsp_valid, 1'b0);
    chk("rst_opc", 32'(bus1.exe_alu_opc_r), 32'(ALU_ADD));
    chk1("rst_sel_pc", bus1.exe_sel_pc_r, 1'b0);
    chk("rst_pc", bus1.exe_pc_r, 32'd0);
    chk("rst_reg1", bus1.exe_reg1_r, 32'd0);
    chk("rst_src2", bus1.exe_src2_r, 32'd0);
    chk1("rst_rsp_id", bus1.rsp_id, 1'b0);
    chk("rst_rsp_data", bus1.rsp_data, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      set_req(tv[i].who, 1'b1, tv[i].opc, tv[i].sp, tv[i].pc,
              tv[i].r1, tv[i].s2);
      #1;
      chk1($sformatf("vec%0d_ready", i),
           tv[i].who ? bus1.r1_ready : bus1.r0_ready, 1'b1);
      tick();
      set_req(tv[i].who, 1'b0, ALU_ADD, 1'b0, 0, 0, 0);
      tick();
      chk1($sformatf("vec%0d_valid", i), bus1.rsp_valid, 1'b1);
      chk1($sformatf("vec%0d_id", i), bus1.rsp_id, tv[i].who);
      chk($sformatf("vec%0d_data", i), bus1.rsp_data, tv[i].res);
      tick();
    end

    // fill both stages, then reset between clock edges
    bus1.rsp_ready = 1'b0;
    rand_req(1'b0, 100);
    rand_req(1'b1, 100);
    tick();
    refresh(100);
    tick();
    chk1("pre_rst_rsp_valid", bus1.rsp_valid, 1'b1);
    set_req(1'b0, 1'b0, ALU_ADD, 1'b0, 0, 0, 0);
    set_req(1'b1, 1'b0, ALU_ADD, 1'b0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk1("async_rst_rsp_valid", bus1.rsp_valid, 1'b0);
    chk("async_rst_opc", 32'(bus1.exe_alu_opc_r), 32'(ALU_ADD));
    chk("async_rst_src2", bus1.exe_src2_r, 32'd0);
    chk("async_rst_data", bus1.rsp_data, 32'd0);
    q.delete();
    last = 1;
    #2;
    reset = 1'b0;
    bus1.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    ecnt++;

    // continuous contention alternates, starting with r0
    set_req(1'b0, 1'b1, ALU_ADD, 1'b0, 0, 32'd10, 32'd1);
    set_req(1'b1, 1'b1, ALU_SUB, 1'b0, 0, 32'd10, 32'd1);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk1($sformatf("rr%0d_r0", i), bus1.r0_ready, (i % 2) == 0);
      chk1($sformatf("rr%0d_r1", i), bus1.r1_ready, (i % 2) == 1);
      tick();
    end
    set_req(1'b0, 1'b0, ALU_ADD, 1'b0, 0, 0, 0);
    set_req(1'b1, 1'b0, ALU_ADD, 1'b0, 0, 0, 0);
    tick();
    tick();

    // backpressure with both stages occupied
    rand_req(1'b0, 100);
    rand_req(1'b1, 100);
    tick();
    refresh(100);
    tick();
    refresh(100);
    bus1.rsp_ready = 1'b0;
    #1;
    d = bus1.rsp_data;
    s = bus1.exe_src2_r;
    o = bus1.exe_alu_opc_r;
    id = bus1.rsp_id;
    for (int i = 0; i < 3; i++) begin
      chk1($sformatf("bp%0d_r0", i), bus1.r0_ready, 1'b0);
      chk1($sformatf("bp%0d_r1", i), bus1.r1_ready, 1'b0);
      tick();
      refresh(100);
      chk($sformatf("bp%0d_data", i), bus1.rsp_data, d);
      chk($sformatf("bp%0d_src2", i), bus1.exe_src2_r, s);
      chk($sformatf("bp%0d_opc", i), 32'(bus1.exe_alu_opc_r),
          32'(o));
      chk1($sformatf("bp%0d_id", i), bus1.rsp_id, id);
    end
    bus1.rsp_ready = 1'b1;
    tick();
    refresh(100);
    set_req(1'b0, 1'b0, ALU_ADD, 1'b0, 0, 0, 0);
    set_req(1'b1, 1'b0, ALU_ADD, 1'b0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("bp_drain", 32'(q.size()), 32'd0);
    chk1("bp_drain_valid", bus1.rsp_valid, 1'b0);

    // ten back-to-back ops from r0
    cnt = 0;
    run = 0;
    maxrun = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 10) set_req(1'b0, 1'b1, ops4[i % 4], 1'b0, 0,
                          $urandom, 32'($urandom_range(0, 40)));
      else set_req(1'b0, 1'b0, ALU_ADD, 1'b0, 0, 0, 0);
      tick();
      if (bus1.rsp_valid) begin
        cnt++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    chk("b2b_count", 32'(cnt), 32'd10);
    chk("b2b_run", 32'(maxrun), 32'd10);

    // randomized traffic with random consumer stalls
    for (int i = 0; i < 300; i++) begin
      bus1.rsp_ready = $urandom_range(0, 3) != 0;
      refresh(60);
      tick();
    end
    set_req(1'b0, 1'b0, ALU_ADD, 1'b0, 0, 0, 0);
    set_req(1'b1, 1'b0, ALU_ADD, 1'b0, 0, 0, 0);
    bus1.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("rand_drain", 32'(q.size()), 32'd0);

    // fixed priority instance: r0 always wins
    bus0.r0_valid = 1'b1;
    bus0.r1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1($sformatf("fp%0d_r0", i), bus0.r0_ready, 1'b1);
      chk1($sformatf("fp%0d_r1", i), bus0.r1_ready, 1'b0);
      tick();
      if (i > 0) begin
        chk1($sformatf("fp%0d_id", i), bus0.rsp_id, 1'b0);
        chk($sformatf("fp%0d_data", i), bus0.rsp_data, 32'd2);
      end
    end
    bus0.r0_valid = 1'b0;
    bus0.r1_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with requester 0 winning.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rN_valid  input  1  requester N (N=0,1) holds a valid ALU operation.
REQ-005 rN_ready  output  1  requester N operation is accepted this cycle.
REQ-006 rN_opc  input  4  requester N ALU opcode (RV32I ALU encoding).
REQ-007 rN_sel_pc  input  1  requester N first-operand select (1 = PC, 0 = reg1).
REQ-008 rN_pc / rN_reg1 / rN_src2  input  32 each  requester N operands.
REQ-009 exe_alu_opc_r  output  4  registered opcode driven to the ALU.
REQ-010 exe_sel_pc_r  output  1  registered PC select driven to the ALU.
REQ-011 exe_pc_r / exe_reg1_r / exe_src2_r  output  32 each  registered operands driven to the ALU.
REQ-012 alu_result  input  32  combinational ALU result for the current exe_* values.
REQ-013 rsp_valid  output  1  response register holds a result.
REQ-014 rsp_ready  input  1  consumer accepts the response this cycle.
REQ-015 rsp_id  output  1  index of the requester that owns rsp_data.
REQ-016 rsp_data  output  32  registered ALU result.

Function
REQ-017 The pipeline SHALL have two stages: issue (exe_* registers plus issue_v and issue_id) and response (rsp_* registers).
REQ-018 The advance condition SHALL be adv = !rsp_valid | rsp_ready.
REQ-019 The issue stage SHALL be free when free = !issue_v | adv.
REQ-020 The grant SHALL be combinational, and rN_ready SHALL equal grantN & rN_valid & free, with at most one rN_ready high per cycle.
REQ-021 With a single valid requester, that requester SHALL be granted.
REQ-022 With both requesters valid, RR_EN=1 SHALL grant the requester not granted last, and RR_EN=0 SHALL grant requester 0.
REQ-023 The last-grant pointer SHALL update only on an accepted transfer (rN_valid & rN_ready).
REQ-024 On an accept, the winner's opc, sel_pc, pc, reg1 and src2 SHALL load into the exe_* registers, issue_id SHALL take the winner's index, and issue_v SHALL be set, all at the same edge.
REQ-025 When issue_v & adv, rsp_data SHALL capture alu_result and rsp_id SHALL capture issue_id, with rsp_valid set at the same edge.
REQ-026 When the issue stage drains and no new accept occurs, issue_v SHALL clear.
REQ-027 When rsp_valid & rsp_ready and there is no issue_v, rsp_valid SHALL clear.
REQ-028 Latency SHALL be 2 cycles: accept at edge E, rsp_valid high after edge E+1 provided rsp_ready was high or the stage was empty.
REQ-029 Throughput SHALL be 1 operation/cycle while rsp_ready stays high.
REQ-030 Backpressure: while rsp_valid & !rsp_ready, the rsp_* and exe_* registers SHALL hold and both rN_ready SHALL be low if issue_v is set.
REQ-031 Simultaneous events: an accept, an issue-to-response move and a response consume SHALL all be allowed in the same cycle with no bubble.
REQ-032 The exe_* registers SHALL hold their last values when no accept occurs.
REQ-033 Requesters SHALL keep their operands stable while rN_valid & !rN_ready, and the block SHALL NOT depend on rN_* when rN_valid is low.

Reset
REQ-034 Asserting reset at any time, including mid-operation, SHALL clear issue_v and rsp_valid, set exe_alu_opc_r to 4'b0000 (ADD), clear all other exe_* registers, rsp_id and rsp_data to 0, and point the last-grant pointer at 1 so that requester 0 wins first; any in-flight operations SHALL be discarded.

Structure
REQ-035 The ALU opcode constants (AND, OR, XOR, ADD, SUB, SLT, SLTU, SLL, SRL, SRA) SHALL reside in shared package alu_pkg, used by both alu and alu_arbiter.
REQ-036 The arbitration SHALL be a sub-module rr_arbiter2 (2-way arbiter with grant pointer, enabled by RR_EN), and the alu SHALL be instantiated outside this block.

Verification
REQ-037 r0 sends ADD, reg1=5, src2=7 with no contention and rsp_ready=1 -> r0_ready is high at edge E, and rsp_valid=1, rsp_id=0, rsp_data=12 after E+1.
REQ-038 r0 and r1 are both valid continuously with RR_EN=1 -> grants alternate 0,1,0,1 and rsp_id follows the same order; with RR_EN=0 -> r0 wins every cycle.
REQ-039 r1 sends ADD, sel_pc=1, pc=0x100, src2=4 -> rsp_data=0x104 and rsp_id=1.
REQ-040 rsp_ready is held low for 3 cycles with both stages full -> rsp_data and exe_* are stable, rN_ready=0 throughout, and on release the results arrive in order with none lost or duplicated.
REQ-041 reset is asserted asynchronously while issue_v=1 and rsp_valid=1 -> both clear immediately without waiting for clk, and after release the first request grants r0.
REQ-042 10 back-to-back requests (XOR, SUB, SLT, SRA mix) with rsp_ready=1 -> 10 consecutive rsp_valid cycles whose results match a reference ALU model.
